prog_fsm_lut: RTL and testbench

- Parametrised successor to the fixed 5-entry jump-table FSM.
- Holds a programmable Moore state machine: a full next-state table and a per-state output word, loaded serially over a one-bit config line.
- After loading, the table drives state transitions selected by a multi-bit input.
- Adds a load handshake, a run/step enable and a sticky illegal-state error.

---
 rtl/prog_fsm_lut_pkg.sv | 33 +++
 rtl/prog_fsm_lut_if.sv | 30 +++
 rtl/prog_fsm_lut_lut_loader.sv | 57 +++++
 rtl/prog_fsm_lut.sv | 134 +++++++++++++
 tb/tb_prog_fsm_lut.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_fsm_lut_pkg.sv
// Shared definitions for the programmable LUT state machine: controller mode
// encodings and helpers describing the packed record layout.
package prog_fsm_pkg;

    // Controller modes
    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_RUN  = 2'd2;
    localparam logic [1:0] MODE_ERR  = 2'd3;

    // Width of one table record: all next-state fields plus the output word.
    function automatic int unsigned rec_w(input int unsigned sw, input int unsigned iw,
                                          input int unsigned ow);
        return (32'd1 << iw) * sw + ow;
    endfunction

    // Total serial bits needed to fill the whole table.
    function automatic int unsigned tot_bits(input int unsigned n, input int unsigned sw,
                                             input int unsigned iw, input int unsigned ow);
        return n * rec_w(sw, iw, ow);
    endfunction

    // LSB of next-state field i within a record.
    function automatic int unsigned next_lsb(input int unsigned i, input int unsigned sw);
        return i * sw;
    endfunction

    // LSB of the output word within a record; it sits above all next fields.
    function automatic int unsigned out_lsb(input int unsigned iw, input int unsigned sw);
        return (32'd1 << iw) * sw;
    endfunction

endpackage

// File: rtl/prog_fsm_lut_if.sv
// Control/status bundle of the programmable LUT state machine.
interface prog_fsm_lut_if #(
    parameter int unsigned SW = 3,
    parameter int unsigned IW = 2,
    parameter int unsigned OW = 5
);
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_bit;
    logic          step_en;
    logic [IW-1:0] in;
    logic          load_done;
    logic          busy;
    logic          running;
    logic          err;
    logic [SW-1:0] cur_state;
    logic [OW-1:0] fsm_out;

    // Stimulus side
    modport master (
        output cfg_start, cfg_valid, cfg_bit, step_en, in,
        input  load_done, busy, running, err, cur_state, fsm_out
    );

    // State machine side
    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, step_en, in,
        output load_done, busy, running, err, cur_state, fsm_out
    );
endinterface

// File: rtl/prog_fsm_lut_lut_loader.sv
// Serial table loader: assembles MSB-first records from the config line and
// emits one write strobe per completed record.
module lut_loader #(
    parameter int unsigned N_STATES = 8,
    parameter int unsigned REC_W    = 17,
    localparam int unsigned CW      = $clog2(REC_W),
    localparam int unsigned IXW     = $clog2(N_STATES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             cfg_bit,
    output logic             rec_we,
    output logic [IXW-1:0]   rec_idx,
    output logic [REC_W-1:0] rec_data,
    output logic             last_rec
);
    localparam logic [CW-1:0]  LAST_BIT = CW'(REC_W - 1);
    localparam logic [IXW-1:0] N_IDX    = IXW'(N_STATES);
    localparam logic [IXW-1:0] LAST_IDX = IXW'(N_STATES - 1);

    logic [REC_W-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic [IXW-1:0]   idx_q;
    logic             rec_end;

    assign rec_end  = shift_en && !clear && (cnt_q == LAST_BIT);
    // Record written on the same edge as its final bit, so present it unshifted.
    assign rec_data = {sr_q[REC_W-2:0], cfg_bit};
    assign rec_we   = rec_end && (idx_q < N_IDX);
    assign rec_idx  = idx_q;
    assign last_rec = rec_we && (idx_q == LAST_IDX);

    // Shift register, bit counter and record index; a restart clears all three.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else if (clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else if (shift_en) begin
            sr_q <= {sr_q[REC_W-2:0], cfg_bit};
            if (cnt_q == LAST_BIT) begin
                cnt_q <= '0;
                if (idx_q != N_IDX) begin
                    idx_q <= idx_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prog_fsm_lut.sv
// Programmable Moore machine: serially loaded next-state/output table, then
// stepped by a multi-bit selector. Illegal next states latch a sticky error.
module prog_fsm_lut
    import prog_fsm_pkg::*;
#(
    parameter int unsigned N_STATES = 8,
    parameter int unsigned SW       = 3,
    parameter int unsigned IW       = 2,
    parameter int unsigned OW       = 5
) (
    input logic            clk,
    input logic            reset,
    prog_fsm_lut_if.slave  bus
);
    localparam int unsigned REC_W = rec_w(SW, IW, OW);
    localparam int unsigned AW    = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam int unsigned IXW   = $clog2(N_STATES) + 1;
    localparam int unsigned OLSB  = out_lsb(IW, SW);
    localparam logic [SW:0] N_LIM = (SW + 1)'(N_STATES);

    logic [REC_W-1:0] tbl_q [N_STATES];
    logic [1:0]       mode_q, mode_d;
    logic [SW-1:0]    cur_q, cur_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             ld_we;
    logic [IXW-1:0]   ld_idx;
    logic [REC_W-1:0] ld_data;
    logic             ld_last;

    logic [REC_W-1:0] row;
    logic [SW-1:0]    nxt;
    logic             legal;

    lut_loader #(
        .N_STATES (N_STATES),
        .REC_W    (REC_W)
    ) u_loader (
        .clk      (clk),
        .reset    (reset),
        .clear    (bus.cfg_start),
        .shift_en (bus.cfg_valid && (mode_q == MODE_LOAD)),
        .cfg_bit  (bus.cfg_bit),
        .rec_we   (ld_we),
        .rec_idx  (ld_idx),
        .rec_data (ld_data),
        .last_rec (ld_last)
    );

    assign row   = tbl_q[cur_q[AW-1:0]];
    assign nxt   = row[next_lsb(32'(bus.in), SW) +: SW];
    assign legal = {1'b0, nxt} < N_LIM;

    // Table storage, written one record at a time by the loader.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_STATES; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (ld_we) begin
            tbl_q[ld_idx[AW-1:0]] <= ld_data;
        end
    end

    // Mode sequencing and state transitions; cfg_start beats step_en everywhere.
    always_comb begin
        mode_d = mode_q;
        cur_d  = cur_q;
        err_d  = err_q;
        done_d = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                if (bus.cfg_start) mode_d = MODE_LOAD;
            end
            MODE_LOAD: begin
                if (ld_last) begin
                    mode_d = MODE_RUN;
                    done_d = 1'b1;
                    cur_d  = '0;
                end
            end
            MODE_RUN: begin
                if (bus.cfg_start) begin
                    mode_d = MODE_LOAD;
                    cur_d  = '0;
                end else if (bus.step_en) begin
                    if (legal) begin
                        cur_d = nxt;
                    end else begin
                        err_d  = 1'b1;
                        mode_d = MODE_ERR;
                    end
                end
            end
            MODE_ERR: begin
                if (bus.cfg_start) begin
                    mode_d = MODE_LOAD;
                    err_d  = 1'b0;
                    cur_d  = '0;
                end
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_IDLE;
            cur_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cur_q  <= cur_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // Status decodes and Moore output, gated off while not executing.
    always_comb begin
        bus.load_done = done_q;
        bus.busy      = (mode_q == MODE_LOAD);
        bus.running   = (mode_q == MODE_RUN);
        bus.err       = err_q;
        bus.cur_state = cur_q;
        bus.fsm_out   = '0;
        if (mode_q == MODE_RUN || mode_q == MODE_ERR) begin
            bus.fsm_out = row[OLSB +: OW];
        end
    end
endmodule

// File: tb/tb_prog_fsm_lut.sv
// Directed bench for prog_fsm_lut: a default 8-state instance and a 6-state
// instance used to reach the illegal-state error.
module tb_prog_fsm_lut;
    localparam int unsigned SW = 3, IW = 2, OW = 5, REC_W = 17;

    logic clk = 1'b0;
    logic rst;
    logic start, valid, cbit, step;
    logic [IW-1:0] sel;
    int tgt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_fsm_lut_if #(.SW(SW), .IW(IW), .OW(OW)) b8 ();
    prog_fsm_lut_if #(.SW(SW), .IW(IW), .OW(OW)) b6 ();

    assign b8.cfg_start = (tgt == 0) ? start : 1'b0;
    assign b8.cfg_valid = (tgt == 0) ? valid : 1'b0;
    assign b8.cfg_bit   = cbit;
    assign b8.step_en   = (tgt == 0) ? step : 1'b0;
    assign b8.in        = sel;
    assign b6.cfg_start = (tgt == 1) ? start : 1'b0;
    assign b6.cfg_valid = (tgt == 1) ? valid : 1'b0;
    assign b6.cfg_bit   = cbit;
    assign b6.step_en   = (tgt == 1) ? step : 1'b0;
    assign b6.in        = sel;

    prog_fsm_lut #(.N_STATES(8), .SW(SW), .IW(IW), .OW(OW)) u8 (
        .clk   (clk),
        .reset (rst),
        .bus   (b8.slave)
    );
    prog_fsm_lut #(.N_STATES(6), .SW(SW), .IW(IW), .OW(OW)) u6 (
        .clk   (clk),
        .reset (rst),
        .bus   (b6.slave)
    );

    logic [SW-1:0] o_state;
    logic [OW-1:0] o_out;
    logic o_done, o_busy, o_run, o_err;
    assign o_state = (tgt == 0) ? b8.cur_state : b6.cur_state;
    assign o_out   = (tgt == 0) ? b8.fsm_out   : b6.fsm_out;
    assign o_done  = (tgt == 0) ? b8.load_done : b6.load_done;
    assign o_busy  = (tgt == 0) ? b8.busy      : b6.busy;
    assign o_run   = (tgt == 0) ? b8.running   : b6.running;
    assign o_err   = (tgt == 0) ? b8.err       : b6.err;

    typedef struct {
        logic          step;
        logic [IW-1:0] sel;
        logic [SW-1:0] st;
        logic [OW-1:0] out;
    } vec_t;

    vec_t cnt_vecs [9];
    logic [REC_W-1:0] recs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk(input int unsigned o, input int unsigned n3,
                                             input int unsigned n2, input int unsigned n1,
                                             input int unsigned n0);
        return {5'(o), 3'(n3), 3'(n2), 3'(n1), 3'(n0)};
    endfunction

    task automatic counter_table(input int n);
        for (int s = 0; s < 8; s++) begin
            recs[s] = mk(s, (s + 1) % n, (s + 1) % n, (s + 1) % n, (s + 1) % n);
        end
    endtask

    // Serially loads n records; abort_at >= 0 stops after that many bits.
    task automatic load_table(input int n, input int gap_pct, input int abort_at);
        int nbits = 0;
        int early = 0;
        int total = n * REC_W;
        start = 1'b1;
        valid = 1'b0;
        tick();
        start = 1'b0;
        chk("load_busy", 32'(o_busy), 32'd1);
        for (int r = 0; r < n; r++) begin
            for (int b = REC_W - 1; b >= 0; b--) begin
                if (abort_at >= 0 && nbits == abort_at) begin
                    valid = 1'b0;
                    return;
                end
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    valid = 1'b0;
                    tick();
                    if (o_done) early++;
                end
                valid = 1'b1;
                cbit  = recs[r][b];
                tick();
                nbits++;
                if (nbits < total && o_done) early++;
            end
        end
        valid = 1'b0;
        chk("no_early_done", 32'(early), 32'd0);
        chk("load_done_pulse", 32'(o_done), 32'd1);
        chk("run_after_load", 32'(o_run), 32'd1);
        chk("state0_after_load", 32'(o_state), 32'd0);
        tick();
        chk("load_done_single", 32'(o_done), 32'd0);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < 9; i++) begin
            step = cnt_vecs[i].step;
            sel  = cnt_vecs[i].sel;
            tick();
            step = 1'b0;
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(cnt_vecs[i].st));
            chk($sformatf("vec%0d_out", i), 32'(o_out), 32'(cnt_vecs[i].out));
        end
    endtask

    initial begin
        cnt_vecs[0] = '{1'b1, 2'd0, 3'd1, 5'd1};
        cnt_vecs[1] = '{1'b1, 2'd0, 3'd2, 5'd2};
        cnt_vecs[2] = '{1'b1, 2'd0, 3'd3, 5'd3};
        cnt_vecs[3] = '{1'b0, 2'd0, 3'd3, 5'd3};
        cnt_vecs[4] = '{1'b1, 2'd0, 3'd4, 5'd4};
        cnt_vecs[5] = '{1'b1, 2'd1, 3'd5, 5'd5};
        cnt_vecs[6] = '{1'b1, 2'd2, 3'd6, 5'd6};
        cnt_vecs[7] = '{1'b1, 2'd3, 3'd7, 5'd7};
        cnt_vecs[8] = '{1'b1, 2'd0, 3'd0, 5'd0};

        tgt = 0;
        rst = 1'b1;
        start = 1'b0; valid = 1'b0; cbit = 1'b0; step = 1'b0; sel = '0;
        tick();
        tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_out", 32'(o_out), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_running", 32'(o_run), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        rst = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("idle_step_state", 32'(o_state), 32'd0);
        chk("idle_step_running", 32'(o_run), 32'd0);

        // Counter table and stepping
        counter_table(8);
        load_table(8, 0, -1);
        run_vecs();

        // Asynchronous reset mid-run
        step = 1'b1; sel = 2'd0;
        tick();
        step = 1'b0;
        chk("pre_reset_state", 32'(o_state), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(o_state), 32'd0);
        chk("midrst_out", 32'(o_out), 32'd0);
        chk("midrst_running", 32'(o_run), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        tick();
        rst = 1'b0;

        // Branching
        counter_table(8);
        recs[0] = mk(0, 1, 5, 1, 1);
        recs[5] = mk(26, 6, 6, 6, 6);
        load_table(8, 0, -1);
        sel = 2'd2; step = 1'b1;
        tick();
        step = 1'b0;
        chk("branch_state", 32'(o_state), 32'd5);
        chk("branch_out", 32'(o_out), 32'h1a);
        tick();
        chk("hold_state", 32'(o_state), 32'd5);
        chk("hold_out", 32'(o_out), 32'h1a);

        // Gapped configuration
        counter_table(8);
        load_table(8, 30, -1);
        run_vecs();

        // Restart mid-load: partial junk load, then a full reload
        for (int s = 0; s < 8; s++) recs[s] = mk(31, 0, 0, 0, 0);
        load_table(8, 0, 50);
        chk("partial_busy", 32'(o_busy), 32'd1);
        counter_table(8);
        load_table(8, 0, -1);
        run_vecs();

        // cfg_start wins over step_en in RUN
        step = 1'b1; sel = 2'd0;
        tick();
        chk("prio_pre_state", 32'(o_state), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        chk("prio_busy", 32'(o_busy), 32'd1);
        chk("prio_running", 32'(o_run), 32'd0);
        chk("prio_state", 32'(o_state), 32'd0);
        load_table(8, 0, -1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("prio_reload_step", 32'(o_state), 32'd1);

        // Illegal next state on the 6-state instance
        tgt = 1;
        counter_table(6);
        recs[0] = mk(21, 1, 1, 7, 1);
        load_table(6, 0, -1);
        sel = 2'd1; step = 1'b1;
        tick();
        step = 1'b0;
        chk("ill_err", 32'(o_err), 32'd1);
        chk("ill_running", 32'(o_run), 32'd0);
        chk("ill_state", 32'(o_state), 32'd0);
        chk("ill_out", 32'(o_out), 32'h15);
        sel = 2'd0; step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        chk("ill_frozen_state", 32'(o_state), 32'd0);
        chk("ill_sticky_err", 32'(o_err), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_clear_err", 32'(o_err), 32'd0);
        chk("ill_clear_busy", 32'(o_busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
